// File: rtl/ahb_reg_pkg.sv
// ahb_reg_pkg: shared AHB-Lite encodings and a byte-lane mask helper for ahb_reg_slave
package ahb_reg_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;
  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction
endpackage

// File: rtl/ahb_byte_strobe_gen.sv
// ahb_byte_strobe_gen: maps AHB hsize and byte offset to a 4-lane byte enable (sizes above word act as word)
module ahb_byte_strobe_gen
  import ahb_reg_pkg::*;
(
  input  logic [2:0] hsize_i,
  input  logic [1:0] off_i,
  output logic [3:0] be_o
);
  // one lane for bytes, an aligned lane pair for halfwords, everything else full word
  always_comb be_o = (hsize_i == HSIZE_BYTE) ? 4'b0001 << off_i :
                     (hsize_i == HSIZE_HALF) ? (off_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
endmodule

// File: rtl/ahb_reg_slave.sv
// ahb_reg_slave: zero-wait AHB-Lite register bank; last register is a read-only ID; optional AHBREG_ERROR_RESP_EN adds two-cycle ERROR responses
module ahb_reg_slave
  import ahb_reg_pkg::*;
#(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned IDX_W    = 2,
  parameter logic [31:0] ID_VALUE = 32'h5253_4131
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] hwdata,
  input  logic        hsel,
  input  logic        hready_in,
  output logic        hready,
  output logic [31:0] hrdata,
  output logic [1:0]  hresp,
  output logic [3:0]  ahbreg0
);
  localparam logic [IDX_W-1:0] ID_IDX = IDX_W'(NUM_REGS - 1);
  logic             acc, mapped, wr_en, unused;
  logic [IDX_W-1:0] idx;
  logic             dp_valid_q, dp_write_q, dp_mapped_q;
  logic [IDX_W-1:0] dp_idx_q;
  logic [1:0]       dp_off_q;
  logic [2:0]       dp_size_q;
  logic [3:0]       be;
  logic [31:0]      mask, rd_val, hrdata_q;
  logic [31:0]      reg_q [NUM_REGS];
  logic [31:0]      reg_d [NUM_REGS];
  assign unused  = ^{hburst, haddr[31:12], htrans[0]};
  assign acc     = hsel & hready_in & htrans[1];
  assign idx     = haddr[IDX_W+1:2];
  assign mapped  = (haddr[11:IDX_W+2] == '0) && (32'(idx) < NUM_REGS);
  assign wr_en   = dp_valid_q & dp_write_q & dp_mapped_q & (dp_idx_q != ID_IDX);
  assign mask    = lane_mask(be);
  assign hrdata  = hrdata_q;
  assign ahbreg0 = reg_q[0][3:0];
  ahb_byte_strobe_gen u_strobe (
    .hsize_i (dp_size_q),
    .off_i   (dp_off_q),
    .be_o    (be)
  );
  // next register image; reading it for the address phase forwards a same-cycle write
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++)
      reg_d[i] = (wr_en && dp_idx_q == IDX_W'(i)) ? (reg_q[i] & ~mask) | (hwdata & mask) : reg_q[i];
  end
  // read value for an accepted address phase
  always_comb rd_val = !mapped ? '0 : (idx == ID_IDX) ? ID_VALUE : reg_d[idx];
  // data-phase capture, register writes and registered read data
  always_ff @(posedge hclk) begin
    if (hresetn) begin
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_mapped_q <= 1'b0;
      dp_idx_q    <= '0;
      dp_off_q    <= '0;
      dp_size_q   <= '0;
      hrdata_q    <= '0;
      for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= '0;
    end else begin
      dp_valid_q <= acc;
      if (acc) begin
        dp_write_q  <= hwrite;
        dp_mapped_q <= mapped;
        dp_idx_q    <= idx;
        dp_off_q    <= haddr[1:0];
        dp_size_q   <= hsize;
      end
      if (acc && !hwrite) hrdata_q <= rd_val;
      for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= reg_d[i];
    end
  end
`ifdef AHBREG_ERROR_RESP_EN
  logic err, err1_q, err2_q;
  assign err    = acc & (!mapped | (hwrite & (idx == ID_IDX)));
  assign hready = ~err1_q;
  assign hresp  = (err1_q | err2_q) ? HRESP_ERROR : HRESP_OKAY;
  // two-cycle ERROR sequencing: wait cycle then completing cycle
  always_ff @(posedge hclk) begin
    if (hresetn) begin
      err1_q <= 1'b0;
      err2_q <= 1'b0;
    end else begin
      err1_q <= err;
      err2_q <= err1_q;
    end
  end
`else
  assign hready = 1'b1;
  assign hresp  = HRESP_OKAY;
`endif
endmodule

// File: tb/tb_ahb_reg_slave.sv
// tb_ahb_reg_slave: directed AHB transfers checked against a per-cycle address-map model plus literal expectations
module tb_ahb_reg_slave;
  import ahb_reg_pkg::*;
  localparam logic [31:0] ID = 32'h5253_4131;
  logic        hclk = 1'b0, hresetn = 1'b1;
  logic [31:0] haddr = '0, hwdata = '0;
  logic [1:0]  htrans = HTRANS_IDLE;
  logic        hwrite = 1'b0, hsel = 1'b0, hready_in = 1'b1;
  logic [2:0]  hsize = HSIZE_WORD, hburst = 3'b000;
  logic        hready;
  logic [31:0] hrdata;
  logic [1:0]  hresp;
  logic [3:0]  ahbreg0;
  int passed = 0, total = 0;
  bit run = 1'b0;
  logic [31:0] m_reg [4];
  logic [31:0] m_rd = '0, p_a = '0;
  logic        p_v = 1'b0, p_w = 1'b0;
  logic [2:0]  p_sz = '0;

  ahb_reg_slave dut (
    .hclk(hclk), .hresetn(hresetn), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hsel(hsel), .hready_in(hready_in),
    .hready(hready), .hrdata(hrdata), .hresp(hresp), .ahbreg0(ahbreg0)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // address map: words 0..2 are RAM, word 3 is the ID, anything else reads 0 and ignores writes
  task automatic model_update(input logic sel, rdy, input logic [1:0] tr, input logic w,
                              input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    int n, base;
    if (hresetn) begin
      for (int i = 0; i < 4; i++) m_reg[i] = '0;
      m_rd = '0;
      p_v = 1'b0;
    end else begin
      if (p_v && p_w && p_a[11:2] < 3) begin
        n    = (p_sz == 0) ? 1 : (p_sz == 1) ? 2 : 4;
        base = (p_sz == 0) ? int'(p_a[1:0]) : (p_sz == 1) ? (p_a[1] ? 2 : 0) : 0;
        for (int b = base; b < base + n; b++) m_reg[p_a[3:2]][8*b +: 8] = wd[8*b +: 8];
      end
      p_v = sel && rdy && (tr == HTRANS_NONSEQ || tr == HTRANS_SEQ);
      if (p_v) begin
        p_w = w; p_a = a; p_sz = sz;
        if (!w) m_rd = (a[11:2] < 3) ? m_reg[a[3:2]] : (a[11:2] == 3) ? ID : 32'h0;
      end
    end
  endtask

  task automatic step(input logic sel, rdy, input logic [1:0] tr, input logic w,
                      input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    hsel = sel; hready_in = rdy; htrans = tr; hwrite = w; haddr = a; hsize = sz; hwdata = wd;
    @(posedge hclk);
    model_update(sel, rdy, tr, w, a, sz, wd);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    step(1'b1, 1'b1, HTRANS_NONSEQ, 1'b1, a, sz, wd);
  endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] wd);
    step(1'b1, 1'b1, HTRANS_NONSEQ, 1'b0, a, HSIZE_WORD, wd);
  endtask
  task automatic idl(input logic [31:0] wd);
    step(1'b0, 1'b1, HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, wd);
  endtask

  always @(negedge hclk) begin
    if (run) begin
      check("cyc_hrdata", hrdata, m_rd);
      check("cyc_ahbreg0", {28'h0, ahbreg0}, {28'h0, m_reg[0][3:0]});
`ifndef AHBREG_ERROR_RESP_EN
      check("cyc_hready", {31'h0, hready}, 32'h1);
      check("cyc_hresp", {30'h0, hresp}, 32'h0);
`endif
    end
  end

  initial begin
    idl(0); idl(0);
    check("rst_hrdata", hrdata, 32'h0);
    check("rst_ahbreg0", {28'h0, ahbreg0}, 32'h0);
    check("rst_hready", {31'h0, hready}, 32'h1);
    check("rst_hresp", {30'h0, hresp}, 32'h0);
    hresetn = 1'b0;
    run = 1'b1;
    wr(32'h8000_0000, HSIZE_WORD, 0); idl(32'd4);
    check("led_after_write", {28'h0, ahbreg0}, 32'h4);
    rd(32'h8000_0001, 0); idl(0);
    check("readback_reg0", hrdata, 32'h0000_0004);
    wr(32'h8000_0004, HSIZE_WORD, 0); wr(32'h8000_0005, HSIZE_BYTE, 32'hFFFF_FFFF);
    idl(32'h0000_AB00); rd(32'h8000_0004, 0); idl(0);
    check("byte_write", hrdata, 32'hFFFF_ABFF);
    rd(32'h8000_000C, 0); idl(0);
    check("id_read", hrdata, ID);
    wr(32'h8000_000C, HSIZE_WORD, 0); rd(32'h8000_000C, 32'h1234); idl(0);
    check("id_readonly", hrdata, ID);
    wr(32'h8000_0008, HSIZE_WORD, 0); rd(32'h8000_0008, 32'hDEAD_BEEF); idl(0);
    check("forward_word", hrdata, 32'hDEAD_BEEF);
    wr(32'h8000_0006, HSIZE_HALF, 0); rd(32'h8000_0004, 32'h1234_5678); idl(0);
    check("forward_half", hrdata, 32'h1234_ABFF);
    step(1'b1, 1'b0, HTRANS_NONSEQ, 1'b1, 32'h8000_0000, HSIZE_WORD, 0); idl(32'h7);
    step(1'b1, 1'b1, HTRANS_IDLE, 1'b1, 32'h8000_0000, HSIZE_WORD, 0); idl(32'h7);
    step(1'b1, 1'b1, HTRANS_BUSY, 1'b1, 32'h8000_0000, HSIZE_WORD, 0); idl(32'h7);
    step(1'b0, 1'b1, HTRANS_NONSEQ, 1'b1, 32'h8000_0000, HSIZE_WORD, 0); idl(32'h7);
    check("gated_led", {28'h0, ahbreg0}, 32'h4);
    step(1'b1, 1'b1, HTRANS_SEQ, 1'b1, 32'h8000_0000, HSIZE_BYTE, 0); idl(32'h77);
    check("seq_led", {28'h0, ahbreg0}, 32'h7);
    rd(32'h8000_0010, 0); idl(0);
    check("unmapped_read", hrdata, 32'h0);
    wr(32'h8000_0010, HSIZE_WORD, 0); idl(32'hFFFF_FFF0);
    rd(32'h8000_0000, 0); idl(0);
    check("unmapped_write_ignored", hrdata, 32'h0000_0077);
    wr(32'h8000_0008, 3'b111, 0); idl(32'h1122_3344); rd(32'h8000_0008, 0); idl(0);
    check("oversize_is_word", hrdata, 32'h1122_3344);
`ifdef AHBREG_ERROR_RESP_EN
    rd(32'h8000_0010, 0);
    check("err1_hready", {31'h0, hready}, 32'h0);
    check("err1_hresp", {30'h0, hresp}, 32'h1);
    step(1'b0, 1'b0, HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 0);
    check("err2_hready", {31'h0, hready}, 32'h1);
    check("err2_hresp", {30'h0, hresp}, 32'h1);
    idl(0);
    check("err_done_hresp", {30'h0, hresp}, 32'h0);
`endif
    wr(32'h8000_0000, HSIZE_WORD, 0);
    hresetn = 1'b1; idl(32'hA); hresetn = 1'b0;
    check("midreset_led", {28'h0, ahbreg0}, 32'h0);
    check("midreset_hrdata", hrdata, 32'h0);
    rd(32'h8000_0000, 0); idl(0);
    check("midreset_reg0", hrdata, 32'h0);
    idl(0);
    run = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
